// File: rtl/skp_tx_sched_if.sv
// Lane-side symbol bus around the SKP scheduler: upstream symbols in, PCS symbols out.
// Handshake: a symbol moves on a rising clk edge only when valid_in & ready_out; while valid_in is
// high and ready_out low the source holds data_in/kcntl_in/sop_in/eop_in stable; ready_out never
// depends on valid_in.
interface skp_tx_sched_if;
  logic       sched_enable;
  logic [7:0] data_in;
  logic       kcntl_in;
  logic       valid_in;
  logic       sop_in;
  logic       eop_in;
  logic       ready_out;
  logic [7:0] data_out;
  logic       kcntl_out;
  logic       valid_out;
  logic       skp_active;
  logic       skp_sent;
  logic       skp_overdue;

  modport master (
    output sched_enable, data_in, kcntl_in, valid_in, sop_in, eop_in,
    input  ready_out, data_out, kcntl_out, valid_out, skp_active, skp_sent, skp_overdue
  );

  modport slave (
    input  sched_enable, data_in, kcntl_in, valid_in, sop_in, eop_in,
    output ready_out, data_out, kcntl_out, valid_out, skp_active, skp_sent, skp_overdue
  );
endinterface

// File: rtl/skp_tx_sched.sv
// Transmit SKP ordered-set scheduler for one lane: counts symbol times and inserts
// COM,SKP,SKP,SKP between packets, stalling upstream while a set is emitted.
module skp_tx_sched #(
  parameter int SKP_INTERVAL = 1180,
  parameter int SKP_LEN      = 4,
  parameter int CNT_W        = 11
) (
  input  logic           clk,
  input  logic           rst,
  skp_tx_sched_if.slave  bus,
  output logic [1:0]     dbg_state_o,
  output logic [1:0]     dbg_pending_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PKT  = 2'd1,
    ST_SKP  = 2'd2
  } state_t;

  localparam logic [7:0]       SYM_COM  = 8'hBC;
  localparam logic [7:0]       SYM_SKP  = 8'h1C;
  localparam logic [1:0]       LAST_IDX = 2'(SKP_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SKP_INTERVAL - 1);

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       pending_q, pending_d;

  logic [7:0] data_out_q, data_out_d;
  logic       kcntl_out_q, kcntl_out_d;
  logic       valid_out_q, valid_out_d;
  logic       skp_active_q, skp_active_d;
  logic       skp_sent_q, skp_sent_d;
  logic       skp_overdue_q, skp_overdue_d;

  logic tick;
  logic skp_last;
  logic skp_dec;
  logic ready_c;
  logic xfer;

  // Ready is a function of registered state only, so it can gate the transfer without a loop.
  always_comb begin
    ready_c = 1'b0;
    if (state_q == ST_PKT) begin
      ready_c = 1'b1;
    end else if (state_q == ST_IDLE && pending_q == 2'd0) begin
      ready_c = 1'b1;
    end
  end

  assign bus.ready_out = ready_c & ~rst;
  assign xfer          = bus.valid_in & bus.ready_out;
  assign skp_last      = (state_q == ST_SKP) && (idx_q == LAST_IDX);
  assign skp_dec       = skp_last && (pending_q != 2'd0);

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (!bus.sched_enable) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      tick  = 1'b1;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // A tick and a completed set in the same cycle cancel; a fourth outstanding tick is dropped.
  always_comb begin
    pending_d     = pending_q;
    skp_overdue_d = 1'b0;
    if (!bus.sched_enable) begin
      pending_d = 2'd0;
    end else if (tick && !skp_dec) begin
      if (pending_q == 2'd3) begin
        skp_overdue_d = 1'b1;
      end else begin
        pending_d = pending_q + 2'd1;
      end
    end else if (!tick && skp_dec) begin
      pending_d = pending_q - 2'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        idx_d = 2'd0;
        if (pending_q != 2'd0) begin
          state_d = ST_SKP;
        end else if (xfer && bus.sop_in && !bus.eop_in) begin
          state_d = ST_PKT;
        end
      end
      ST_PKT: begin
        idx_d = 2'd0;
        // Going straight to SKP lets the set follow the eop symbol without an idle gap.
        if (xfer && bus.eop_in) begin
          state_d = (pending_d != 2'd0) ? ST_SKP : ST_IDLE;
        end
      end
      ST_SKP: begin
        idx_d = idx_q + 2'd1;
        if (skp_last) begin
          idx_d   = 2'd0;
          state_d = (pending_d != 2'd0) ? ST_SKP : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 2'd0;
      end
    endcase
  end

  always_comb begin
    data_out_d   = 8'h00;
    kcntl_out_d  = 1'b0;
    valid_out_d  = 1'b0;
    skp_active_d = 1'b0;
    skp_sent_d   = 1'b0;
    if (xfer) begin
      data_out_d  = bus.data_in;
      kcntl_out_d = bus.kcntl_in;
      valid_out_d = 1'b1;
    end else if (state_q == ST_SKP) begin
      data_out_d   = (idx_q == 2'd0) ? SYM_COM : SYM_SKP;
      kcntl_out_d  = 1'b1;
      valid_out_d  = 1'b1;
      skp_active_d = 1'b1;
      skp_sent_d   = skp_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= 2'd0;
      cnt_q         <= '0;
      pending_q     <= 2'd0;
      data_out_q    <= 8'h00;
      kcntl_out_q   <= 1'b0;
      valid_out_q   <= 1'b0;
      skp_active_q  <= 1'b0;
      skp_sent_q    <= 1'b0;
      skp_overdue_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      data_out_q    <= data_out_d;
      kcntl_out_q   <= kcntl_out_d;
      valid_out_q   <= valid_out_d;
      skp_active_q  <= skp_active_d;
      skp_sent_q    <= skp_sent_d;
      skp_overdue_q <= skp_overdue_d;
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.kcntl_out   = kcntl_out_q;
  assign bus.valid_out   = valid_out_q;
  assign bus.skp_active  = skp_active_q;
  assign bus.skp_sent    = skp_sent_q;
  assign bus.skp_overdue = skp_overdue_q;
  assign dbg_state_o     = state_q;
  assign dbg_pending_o   = pending_q;

endmodule

// File: tb/tb_skp_tx_sched.sv
// Directed bench for skp_tx_sched: interval-16 instance for most scenarios, interval-48
// instance for the single-tick-inside-a-packet case.
module tb_skp_tx_sched;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  skp_tx_sched_if bus();
  skp_tx_sched_if bus_l();
  logic [1:0] dbg_state, dbg_pending, dbg_state_l, dbg_pending_l;

  skp_tx_sched #(.SKP_INTERVAL(16), .SKP_LEN(4), .CNT_W(11)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state_o(dbg_state), .dbg_pending_o(dbg_pending)
  );

  skp_tx_sched #(.SKP_INTERVAL(48), .SKP_LEN(4), .CNT_W(11)) u_dut_l (
    .clk(clk), .rst(rst), .bus(bus_l), .dbg_state_o(dbg_state_l), .dbg_pending_o(dbg_pending_l)
  );

  localparam logic [8:0] K_COM = 9'h1BC;
  localparam logic [8:0] K_SKP = 9'h11C;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [8:0] exp_q[$];

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic idle_inputs();
    bus.valid_in = 1'b0;   bus.sop_in = 1'b0;   bus.eop_in = 1'b0;
    bus.data_in = 8'h00;   bus.kcntl_in = 1'b0;
    bus_l.valid_in = 1'b0; bus_l.sop_in = 1'b0; bus_l.eop_in = 1'b0;
    bus_l.data_in = 8'h00; bus_l.kcntl_in = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    bus.sched_enable   = 1'b0;
    bus_l.sched_enable = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.sched_enable = 1'b1;
    bus.valid_in = 1'b1; bus.sop_in = 1'b1; bus.data_in = 8'h5A;
    step(2);
    tests_run++;
    if ({bus.ready_out, bus.valid_out, bus.kcntl_out, bus.skp_active, bus.skp_sent,
         bus.skp_overdue, bus.data_out} !== 14'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b k=%b act=%b sent=%b ovd=%b data=%h expected all 0",
               bus.ready_out, bus.valid_out, bus.kcntl_out, bus.skp_active, bus.skp_sent,
               bus.skp_overdue, bus.data_out);
    end
    tests_run++;
    if ({dbg_state, dbg_pending} !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_state: got state=%0d pending=%0d expected 0/0", dbg_state, dbg_pending);
    end
    idle_inputs();
  endtask

  // T1: tick in cycle 15, IDLE decision in 16, set selected in 17-20, visible on data_out after edges 18-21.
  task automatic test_idle_sets();
    logic [8:0] e;
    do_reset();
    bus.sched_enable = 1'b1;
    step(15);
    tests_run++;
    if (bus.ready_out !== 1'b1 || dbg_pending !== 2'd0) begin
      tests_failed++;
      $display("FAIL t1_pre_tick: got rdy=%b pending=%0d expected 1/0", bus.ready_out, dbg_pending);
    end
    step(1);
    tests_run++;
    if (bus.ready_out !== 1'b0 || dbg_pending !== 2'd1) begin
      tests_failed++;
      $display("FAIL t1_decision: got rdy=%b pending=%0d expected 0/1", bus.ready_out, dbg_pending);
    end
    step(1);
    exp_q = {K_COM, K_SKP, K_SKP, K_SKP};
    for (int i = 0; i < 4; i++) begin
      step(1);
      e = exp_q.pop_front();
      tests_run++;
      if ({bus.kcntl_out, bus.data_out} !== e || bus.valid_out !== 1'b1 ||
          bus.skp_active !== 1'b1 || bus.skp_sent !== (i == 3)) begin
        tests_failed++;
        $display("FAIL t1_sym%0d: got k/data=%h vld=%b act=%b sent=%b expected %h 1 1 %b",
                 i, {bus.kcntl_out, bus.data_out}, bus.valid_out, bus.skp_active, bus.skp_sent,
                 e, (i == 3));
      end
    end
    step(1);
    tests_run++;
    if (bus.valid_out !== 1'b0 || bus.ready_out !== 1'b1 || bus.data_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL t1_after_set: got vld=%b rdy=%b data=%h expected 0 1 00",
               bus.valid_out, bus.ready_out, bus.data_out);
    end
    step(12);
    tests_run++;
    if ({bus.kcntl_out, bus.data_out} !== K_COM || bus.skp_active !== 1'b1) begin
      tests_failed++;
      $display("FAIL t1_repeat: got k/data=%h act=%b expected %h 1",
               {bus.kcntl_out, bus.data_out}, bus.skp_active, K_COM);
    end
  endtask

  // T2 on the interval-48 instance: byte 10 lands on the tick cycle (cnt=47).
  task automatic test_packet_tick();
    int err;
    int stalls;
    logic [8:0] e;
    do_reset();
    bus_l.sched_enable = 1'b1;
    step(37);
    err = 0;
    for (int i = 0; i < 40; i++) begin
      bus_l.valid_in = 1'b1; bus_l.kcntl_in = 1'b0;
      bus_l.data_in  = 8'(8'h40 + i);
      bus_l.sop_in   = (i == 0);
      bus_l.eop_in   = (i == 39);
      if (bus_l.ready_out !== 1'b1) err++;
      step(1);
      if (bus_l.data_out !== 8'(8'h40 + i) || bus_l.valid_out !== 1'b1 || bus_l.skp_active !== 1'b0) err++;
      if (i == 10) begin
        tests_run++;
        if (dbg_pending_l !== 2'd1) begin
          tests_failed++;
          $display("FAIL t2_pending_mid: got %0d expected 1", dbg_pending_l);
        end
      end
    end
    idle_inputs();
    tests_run++;
    if (err != 0) begin
      tests_failed++;
      $display("FAIL t2_bytes: got %0d stalled or wrong bytes expected 0", err);
    end
    stalls = 0;
    exp_q = {K_COM, K_SKP, K_SKP, K_SKP};
    for (int j = 0; j < 5; j++) begin
      if (bus_l.ready_out === 1'b0) stalls++;
      if (j < 4) begin
        step(1);
        e = exp_q.pop_front();
        tests_run++;
        if ({bus_l.kcntl_out, bus_l.data_out} !== e || bus_l.skp_active !== 1'b1) begin
          tests_failed++;
          $display("FAIL t2_sym%0d: got k/data=%h act=%b expected %h 1",
                   j, {bus_l.kcntl_out, bus_l.data_out}, bus_l.skp_active, e);
        end
      end
    end
    tests_run++;
    if (stalls != 4 || dbg_pending_l !== 2'd0) begin
      tests_failed++;
      $display("FAIL t2_stall: got stalls=%0d pending=%0d expected 4/0", stalls, dbg_pending_l);
    end
  endtask

  // T3: 60-byte packet from cycle 5 to 64 spans ticks at 15,31,47,63; the one at 63 overflows.
  task automatic test_overdue();
    int err, ovd, rz, sent, sym_err;
    logic [8:0] e;
    do_reset();
    bus.sched_enable = 1'b1;
    step(5);
    err = 0; ovd = 0;
    for (int i = 0; i < 60; i++) begin
      bus.valid_in = 1'b1; bus.kcntl_in = 1'b0;
      bus.data_in  = 8'(8'h80 + i);
      bus.sop_in   = (i == 0);
      bus.eop_in   = (i == 59);
      if (bus.ready_out !== 1'b1) err++;
      step(1);
      if (bus.data_out !== 8'(8'h80 + i) || bus.valid_out !== 1'b1) err++;
      if (bus.skp_overdue === 1'b1) ovd++;
      if (i == 44) begin
        tests_run++;
        if (dbg_pending !== 2'd3) begin
          tests_failed++;
          $display("FAIL t3_pending_full: got %0d expected 3", dbg_pending);
        end
      end
    end
    idle_inputs();
    tests_run++;
    if (err != 0 || ovd != 1) begin
      tests_failed++;
      $display("FAIL t3_packet: got byte_err=%0d overdue_pulses=%0d expected 0/1", err, ovd);
    end
    rz = 0; sent = 0; sym_err = 0;
    for (int j = 0; j < 12; j++) begin
      if (bus.ready_out === 1'b0) rz++;
      step(1);
      e = ((j % 4) == 0) ? K_COM : K_SKP;
      if ({bus.kcntl_out, bus.data_out} !== e || bus.skp_active !== 1'b1) sym_err++;
      if (bus.skp_sent === 1'b1) sent++;
      if (bus.skp_overdue === 1'b1) ovd++;
    end
    tests_run++;
    if (sym_err != 0 || sent != 3) begin
      tests_failed++;
      $display("FAIL t3_sets: got sym_err=%0d sent=%0d expected 0/3", sym_err, sent);
    end
    tests_run++;
    if (rz != 12 || bus.ready_out !== 1'b1 || dbg_pending !== 2'd0 || ovd != 1) begin
      tests_failed++;
      $display("FAIL t3_drain: got stall=%0d rdy=%b pending=%0d ovd=%0d expected 12 1 0 1",
               rz, bus.ready_out, dbg_pending, ovd);
    end
  endtask

  // T4: a single-symbol packet offered while one set is owed waits IDLE-decision + 4 SKP cycles.
  task automatic test_held_sop();
    int stalls;
    logic [8:0] obs_q[$];
    do_reset();
    bus.sched_enable = 1'b1;
    step(16);
    bus.valid_in = 1'b1; bus.sop_in = 1'b1; bus.eop_in = 1'b1;
    bus.data_in = 8'hA5; bus.kcntl_in = 1'b0;
    stalls = 0;
    for (int t = 0; t < 20 && bus.ready_out !== 1'b1; t++) begin
      stalls++;
      step(1);
      if (bus.valid_out === 1'b1) obs_q.push_back({bus.kcntl_out, bus.data_out});
    end
    tests_run++;
    if (stalls != 5) begin
      tests_failed++;
      $display("FAIL t4_stall: got %0d stall cycles expected 5", stalls);
    end
    exp_q = {K_COM, K_SKP, K_SKP, K_SKP};
    tests_run++;
    if (obs_q != exp_q) begin
      tests_failed++;
      $display("FAIL t4_set: got %0d symbols first=%h expected 4 starting %h",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 9'h0, K_COM);
    end
    step(1);
    idle_inputs();
    tests_run++;
    if ({bus.kcntl_out, bus.data_out} !== 9'h0A5 || bus.valid_out !== 1'b1 || bus.skp_active !== 1'b0) begin
      tests_failed++;
      $display("FAIL t4_sop_byte: got k/data=%h vld=%b act=%b expected 0a5 1 0",
               {bus.kcntl_out, bus.data_out}, bus.valid_out, bus.skp_active);
    end
  endtask

  // T5: disable while SKP index 1 is being selected.
  task automatic test_enable_drop();
    int stray;
    do_reset();
    bus.sched_enable = 1'b1;
    step(18);
    bus.sched_enable = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step(1);
      tests_run++;
      if ({bus.kcntl_out, bus.data_out} !== K_SKP || bus.skp_sent !== (j == 2)) begin
        tests_failed++;
        $display("FAIL t5_finish%0d: got k/data=%h sent=%b expected %h %b",
                 j, {bus.kcntl_out, bus.data_out}, bus.skp_sent, K_SKP, (j == 2));
      end
    end
    stray = 0;
    for (int j = 0; j < 30; j++) begin
      step(1);
      if (bus.valid_out !== 1'b0 || dbg_pending !== 2'd0) stray++;
    end
    tests_run++;
    if (stray != 0) begin
      tests_failed++;
      $display("FAIL t5_disabled: got %0d active cycles expected 0", stray);
    end
    bus.sched_enable = 1'b1;
    step(15);
    tests_run++;
    if (dbg_pending !== 2'd0) begin
      tests_failed++;
      $display("FAIL t5_reen_early: got pending=%0d expected 0", dbg_pending);
    end
    step(1);
    tests_run++;
    if (dbg_pending !== 2'd1) begin
      tests_failed++;
      $display("FAIL t5_reen_tick: got pending=%0d expected 1", dbg_pending);
    end
    step(2);
    tests_run++;
    if ({bus.kcntl_out, bus.data_out} !== K_COM) begin
      tests_failed++;
      $display("FAIL t5_reen_set: got k/data=%h expected %h", {bus.kcntl_out, bus.data_out}, K_COM);
    end
  endtask

  // T6: reset while SKP index 2 is being selected.
  task automatic test_rst_mid_set();
    int stray;
    do_reset();
    bus.sched_enable = 1'b1;
    step(19);
    rst = 1'b1;
    step(1);
    tests_run++;
    if ({bus.ready_out, bus.valid_out, bus.skp_active, bus.skp_sent, bus.data_out} !== 12'h0 ||
        dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL t6_truncate: got rdy=%b vld=%b act=%b data=%h state=%0d expected all 0",
               bus.ready_out, bus.valid_out, bus.skp_active, bus.data_out, dbg_state);
    end
    rst = 1'b0;
    stray = 0;
    for (int j = 0; j < 15; j++) begin
      step(1);
      if (bus.valid_out !== 1'b0 || dbg_pending !== 2'd0) stray++;
    end
    tests_run++;
    if (stray != 0) begin
      tests_failed++;
      $display("FAIL t6_quiet: got %0d active cycles expected 0", stray);
    end
    step(1);
    tests_run++;
    if (dbg_pending !== 2'd1) begin
      tests_failed++;
      $display("FAIL t6_tick: got pending=%0d expected 1", dbg_pending);
    end
    step(2);
    tests_run++;
    if ({bus.kcntl_out, bus.data_out} !== K_COM) begin
      tests_failed++;
      $display("FAIL t6_set: got k/data=%h expected %h", {bus.kcntl_out, bus.data_out}, K_COM);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    bus.sched_enable   = 1'b0;
    bus_l.sched_enable = 1'b0;
    @(negedge clk);
    test_reset();
    test_idle_sets();
    test_packet_tick();
    test_overdue();
    test_held_sop();
    test_enable_drop();
    test_rst_mid_set();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1, "watchdog");
  end
endmodule
